// File: rtl/sram_hs_pkg.sv
// Shared types and constants for the multi-outstanding SRAM-like handshake.
// id_t note: ids are plain logic [ID_W-1:0]. ID_NONE supplies the all-ones "no id" value for ID_W <= 64.
package sram_hs_pkg;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_HOLD = 1'b1
    } hs_state_e;

    localparam logic [0:0] ST_IDLE = HS_IDLE;
    localparam logic [0:0] ST_HOLD = HS_HOLD;

    localparam logic [63:0] ID_NONE = '1;

endpackage

// File: rtl/sram_like_mo_handshake_if.sv
// Stage/bus-side signal bundle for sram_like_mo_handshake.
// The flush signal exists only when SRAM_MO_HS_FLUSH_EN is defined.
interface sram_like_mo_handshake_if #(
    parameter int ID_W  = 32,
    parameter int CNT_W = 3
);
    logic [ID_W-1:0]  unique_id;
    logic             need_req;
    logic             addr_ok;
    logic             data_ok;
`ifdef SRAM_MO_HS_FLUSH_EN
    logic             flush;
`endif
    logic             req;
    logic             busy;
    logic             resp_valid;
    logic [ID_W-1:0]  resp_id;
    logic [CNT_W-1:0] outstanding;

`ifdef SRAM_MO_HS_FLUSH_EN
    modport master (output unique_id, need_req, addr_ok, data_ok, flush,
                    input  req, busy, resp_valid, resp_id, outstanding);
    modport slave  (input  unique_id, need_req, addr_ok, data_ok, flush,
                    output req, busy, resp_valid, resp_id, outstanding);
`else
    modport master (output unique_id, need_req, addr_ok, data_ok,
                    input  req, busy, resp_valid, resp_id, outstanding);
    modport slave  (input  unique_id, need_req, addr_ok, data_ok,
                    output req, busy, resp_valid, resp_id, outstanding);
`endif

endinterface

// File: rtl/sram_hs_id_fifo.sv
// Synchronous id FIFO with simultaneous push/pop; pointers wrap modulo DEPTH.
// Storage is not reset, only pointers and count.
module sram_hs_id_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram_like_mo_handshake.sv
// SRAM-like requester with up to MAX_OUTSTANDING accepted requests, id dedup and in-order response tagging.
// Optional SRAM_MO_HS_FLUSH_EN adds flush with discard of in-flight responses.
module sram_like_mo_handshake
    import sram_hs_pkg::*;
#(
    parameter int ID_W            = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_like_mo_handshake_if.slave  bus
);
    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [ID_W-1:0]  hold_id_q, hold_id_d;

    logic [ID_W-1:0]  fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push, fifo_pop;

    logic             full, req, accept, retire, bypass, resp_valid, flush_now;
    logic [ID_W-1:0]  issue_id, resp_id;

`ifdef SRAM_MO_HS_FLUSH_EN
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             hold_flushed_q, hold_flushed_d;
    logic             discarding;

    assign flush_now  = bus.flush;
    assign discarding = (discard_q != '0);
`else
    assign flush_now  = 1'b0;
`endif

    assign full     = (fifo_count == CNT_W'(MAX_OUTSTANDING));
    assign issue_id = (state_q == ST_HOLD) ? hold_id_q : bus.unique_id;

    always_comb begin
        req = 1'b0;
        if (!rst) begin
            if (state_q == ST_HOLD) req = 1'b1;
            else req = bus.need_req && (bus.unique_id != last_id_q) && !full && !flush_now;
        end
    end

    assign accept = req && bus.addr_ok;
    assign retire = bus.data_ok && ((fifo_count != '0) || accept);
    // A response arriving with the FIFO empty can only belong to the request accepted this cycle.
    assign bypass    = retire && (fifo_count == '0);
    assign fifo_push = accept && !bypass;
    assign fifo_pop  = retire && !bypass;
    assign resp_id   = bypass ? issue_id : fifo_head;

`ifdef SRAM_MO_HS_FLUSH_EN
    assign resp_valid = retire && !discarding;
`else
    assign resp_valid = retire;
`endif

    sram_hs_id_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (issue_id),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        done_id_d = done_id_q;
        hold_id_d = hold_id_q;

        if (state_q == ST_IDLE) begin
            if (req && !bus.addr_ok) begin
                state_d   = ST_HOLD;
                hold_id_d = bus.unique_id;
            end
        end else if (bus.addr_ok) begin
            state_d = ST_IDLE;
        end

        if (accept) last_id_d = issue_id;
        if (resp_valid) done_id_d = resp_id;

`ifdef SRAM_MO_HS_FLUSH_EN
        hold_flushed_d = hold_flushed_q;
        discard_d      = discard_q;
        // A held request flushed before acceptance is still owed a response, which must be dropped.
        if (accept && hold_flushed_q) begin
            last_id_d      = last_id_q;
            hold_flushed_d = 1'b0;
        end
        if (flush_now) begin
            last_id_d      = ID_NONE[ID_W-1:0];
            discard_d      = fifo_count + CNT_W'(accept) - CNT_W'(retire);
            hold_flushed_d = (state_q == ST_HOLD) && !accept;
        end else begin
            discard_d = discard_q + CNT_W'(accept && hold_flushed_q)
                                  - CNT_W'(retire && discarding);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_id_q <= ID_NONE[ID_W-1:0];
            done_id_q <= ID_NONE[ID_W-1:0];
            hold_id_q <= '0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            done_id_q <= done_id_d;
            hold_id_q <= hold_id_d;
        end
    end

`ifdef SRAM_MO_HS_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_q      <= '0;
            hold_flushed_q <= 1'b0;
        end else begin
            discard_q      <= discard_d;
            hold_flushed_q <= hold_flushed_d;
        end
    end
`endif

    assign bus.req         = req;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_id     = resp_id;
    assign bus.outstanding = fifo_count;
    assign bus.busy        = bus.need_req
                           && ((bus.unique_id == last_id_q) || (state_q == ST_HOLD))
                           && (bus.unique_id != done_id_q)
                           && !(resp_valid && (resp_id == bus.unique_id));

endmodule
